dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate controller sequencing the data-cache data array (`Cache02Data` datapath) and the main-memory port. Owns the tag/valid store, computes hit, stalls the CPU on misses and writes, runs line refills word by word over a req/ack memory handshake, and steers the data-array write port. Sits between the CPU memory stage and the cache data RAM / main memory.

---
 rtl/dcache_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Optional statistics counters enabled by defining DCACHE_CTRL_STATS_EN.
module dcache_ctrl #(
    parameter int INDEX_W    = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cpu_req,
    input  logic                                cpu_we,
    input  logic [31:0]                         cpu_addr,
    input  logic [31:0]                         cpu_wdata,
    output logic [31:0]                         cpu_rdata,
    output logic                                cpu_stall,
    output logic                                hit,
    output logic [INDEX_W+$clog2(LINE_WORDS)-1:0] dram_addr,
    output logic                                dram_we,
    output logic [31:0]                         dram_wdata,
    input  logic [31:0]                         dram_rdata,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [31:0]                         mem_addr,
    output logic [31:0]                         mem_wdata,
    input  logic                                mem_ack,
    input  logic [31:0]                         mem_rdata,
    output logic [31:0]                         hit_cnt,
    output logic [31:0]                         miss_cnt
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 32 - INDEX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WTHRU,
        FILL_DONE
    } state_t;

    state_t state, state_nx;

    logic [OFF_W-1:0]   off;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;

    logic [TAG_W-1:0]   tags [LINES];
    logic [LINES-1:0]   valid;
    logic [OFF_W-1:0]   cnt;
    logic [TAG_W-1:0]   rtag;
    logic [INDEX_W-1:0] ridx;
    logic [31:0]        waddr;
    logic [31:0]        wdata_r;

    logic start_fill;
    logic start_wr;
    logic fill_last;

    assign off = cpu_addr[OFF_W+1:2];
    assign idx = cpu_addr[OFF_W+INDEX_W+1:OFF_W+2];
    assign tag = cpu_addr[31:OFF_W+INDEX_W+2];

    assign hit       = valid[idx] && (tags[idx] == tag);
    assign cpu_rdata = dram_rdata;

    always_comb begin
        state_nx   = state;
        cpu_stall  = 1'b0;
        dram_addr  = {idx, off};
        dram_we    = 1'b0;
        dram_wdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        start_fill = 1'b0;
        start_wr   = 1'b0;
        fill_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        cpu_stall = 1'b1;
                        start_wr  = 1'b1;
                        state_nx  = WTHRU;
                        if (hit) begin
                            dram_we    = 1'b1;
                            dram_wdata = cpu_wdata;
                        end
                    end else if (!hit) begin
                        cpu_stall  = 1'b1;
                        start_fill = 1'b1;
                        state_nx   = REFILL;
                    end
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {rtag, ridx, cnt, 2'b00};
                dram_addr = {ridx, cnt};
                if (mem_ack) begin
                    dram_we    = 1'b1;
                    dram_wdata = mem_rdata;
                    if (cnt == LAST) begin
                        fill_last = 1'b1;
                        state_nx  = FILL_DONE;
                    end
                end
            end
            WTHRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = waddr;
                mem_wdata = wdata_r;
                cpu_stall = !mem_ack;
                if (mem_ack) begin
                    state_nx = IDLE;
                end
            end
            FILL_DONE: begin
                cpu_stall = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The line is invalidated at refill start so a partial fill never hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= '0;
            cnt     <= '0;
            rtag    <= '0;
            ridx    <= '0;
            waddr   <= '0;
            wdata_r <= '0;
        end else begin
            state <= state_nx;
            if (start_fill) begin
                cnt        <= '0;
                rtag       <= tag;
                ridx       <= idx;
                valid[idx] <= 1'b0;
            end
            if (state == REFILL && mem_ack) begin
                cnt <= cnt + 1'b1;
            end
            if (fill_last) begin
                valid[ridx] <= 1'b1;
            end
            if (start_wr) begin
                waddr   <= cpu_addr & ~32'd3;
                wdata_r <= cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_last) begin
            tags[ridx] <= rtag;
        end
    end

`ifdef DCACHE_CTRL_STATS_EN
    logic [31:0] hc;
    logic [31:0] mc;

    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            mc <= '0;
        end else begin
            if (state == IDLE && cpu_req && !cpu_we && hit) begin
                hc <= hc + 32'd1;
            end
            if (start_fill) begin
                mc <= mc + 32'd1;
            end
        end
    end

    assign hit_cnt  = hc;
    assign miss_cnt = mc;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: vector table plus memory scoreboard.
// Memory responder acks after a programmable number of wait cycles.
module tb_dcache_ctrl;

    localparam int INDEX_W    = 6;
    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int AW         = INDEX_W + OFF_W;
    localparam int LINE_BYTES = LINE_WORDS * 4;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          hit;
    logic [AW-1:0] dram_addr;
    logic          dram_we;
    logic [31:0]   dram_wdata;
    logic [31:0]   dram_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;

    dcache_ctrl #(
        .INDEX_W    (INDEX_W),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .hit        (hit),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Data array: asynchronous read, synchronous write.
    logic [31:0] dram_mem [1 << AW];
    assign dram_rdata = dram_mem[dram_addr];
    always @(posedge clk) begin
        if (dram_we) dram_mem[dram_addr] <= dram_wdata;
    end

    // Main memory: written words remembered, others read as word address * 3.
    logic [31:0] memw [bit [31:0]];

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (memw.exists(a)) return memw[a];
        return (a >> 2) * 32'd3;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t sbq[$];
    req_t rsp_e;
    int   mem_delay = 0;
    int   wcnt = 0;
    int   acks = 0;

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wcnt >= mem_delay) begin
                wcnt    = 0;
                mem_ack = 1'b1;
                acks++;
                if (mem_we) memw[mem_addr] = mem_wdata;
                else mem_rdata = rd_model(mem_addr);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_unexpected: got addr %h we %0b want none",
                             mem_addr, mem_we);
                end else begin
                    rsp_e = sbq.pop_front();
                    chk("mem_addr", mem_addr, rsp_e.addr);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, rsp_e.we});
                    if (rsp_e.we) chk("mem_wdata", mem_wdata, rsp_e.data);
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic do_access(input logic [31:0] a, input logic w,
                             input logic [31:0] d, output int st,
                             output logic [31:0] rd, output logic we0,
                             output logic ok);
        cpu_addr  = a;
        cpu_we    = w;
        cpu_wdata = d;
        cpu_req   = 1'b1;
        st  = 0;
        rd  = '0;
        ok  = 1'b0;
        #1;
        we0 = dram_we;
        for (int i = 0; i < 200; i++) begin
            if (i != 0) #1;
            if (!cpu_stall) begin
                rd = cpu_rdata;
                ok = 1'b1;
                break;
            end
            st++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] exp_rd;
        int          exp_stall;
        logic        miss;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          st;
        logic [31:0] rd;
        logic        we0;
        logic        ok;
        int          exp_hits;
        int          exp_miss;
        int          a0;
        logic        seen;
        logic [31:0] base;

        for (int i = 0; i < (1 << AW); i++) dram_mem[i] = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        exp_hits  = 0;
        exp_miss  = 0;

        vecs.push_back('{32'h40,   1'b0, 32'h0,        0, 32'h30,       6, 1'b1, 1'b1});
        vecs.push_back('{32'h44,   1'b0, 32'h0,        0, 32'h33,       0, 1'b0, 1'b1});
        vecs.push_back('{32'h4C,   1'b0, 32'h0,        0, 32'h39,       0, 1'b0, 1'b1});
        vecs.push_back('{32'h48,   1'b1, 32'h12345678, 0, 32'h0,        1, 1'b0, 1'b1});
        vecs.push_back('{32'h48,   1'b0, 32'h0,        0, 32'h12345678, 0, 1'b0, 1'b1});
        vecs.push_back('{32'h1000, 1'b1, 32'hCAFEF00D, 0, 32'h0,        1, 1'b0, 1'b0});
        vecs.push_back('{32'h1000, 1'b0, 32'h0,        0, 32'hCAFEF00D, 6, 1'b1, 1'b1});
        vecs.push_back('{32'h40,   1'b0, 32'h0,        0, 32'h30,       0, 1'b0, 1'b1});
        vecs.push_back('{32'h440,  1'b0, 32'h0,        0, 32'h330,      6, 1'b1, 1'b1});
        vecs.push_back('{32'h40,   1'b0, 32'h0,        0, 32'h30,       6, 1'b1, 1'b1});
        vecs.push_back('{32'h200,  1'b0, 32'h0,        1, 32'h180,     10, 1'b1, 1'b1});
        vecs.push_back('{32'h204,  1'b1, 32'hA5A5A5A5, 1, 32'h0,        2, 1'b0, 1'b1});
        vecs.push_back('{32'h204,  1'b0, 32'h0,        0, 32'hA5A5A5A5, 0, 1'b0, 1'b1});
        vecs.push_back('{32'h300,  1'b0, 32'h0,        2, 32'h240,     14, 1'b1, 1'b1});

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_dram_we", {31'd0, dram_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_dram_wdata", dram_wdata, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        cpu_addr = 32'h40;
        #1;
        chk("rst_hit", {31'd0, hit}, 32'd0);
        cpu_req = 1'b1;
        #1;
        chk("rst_req_stall", {31'd0, cpu_stall}, 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        #1;

        foreach (vecs[k]) begin
            mem_delay = vecs[k].delay;
            if (vecs[k].we) begin
                sbq.push_back('{1'b1, vecs[k].addr & ~32'd3, vecs[k].wdata});
            end
            if (vecs[k].miss) begin
                base = vecs[k].addr & ~32'(LINE_BYTES - 1);
                for (int w = 0; w < LINE_WORDS; w++) begin
                    sbq.push_back('{1'b0, base + 32'(4 * w), 32'd0});
                end
            end
            do_access(vecs[k].addr, vecs[k].we, vecs[k].wdata, st, rd, we0, ok);
            chk($sformatf("v%0d_done", k), {31'd0, ok}, 32'd1);
            chk($sformatf("v%0d_stall", k), 32'(st), 32'(vecs[k].exp_stall));
            if (vecs[k].we) begin
                chk($sformatf("v%0d_dram_we", k), {31'd0, we0},
                    {31'd0, vecs[k].exp_hit});
            end else begin
                chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rd);
                exp_hits++;
                if (vecs[k].miss) exp_miss++;
            end
            chk($sformatf("v%0d_hit", k), {31'd0, hit}, {31'd0, vecs[k].exp_hit});
        end

`ifdef DCACHE_CTRL_STATS_EN
        chk("hit_cnt", hit_cnt, 32'(exp_hits));
        chk("miss_cnt", miss_cnt, 32'(exp_miss));
`else
        chk("hit_cnt", hit_cnt, 32'd0);
        chk("miss_cnt", miss_cnt, 32'd0);
`endif
        chk("sbq_empty", 32'(sbq.size()), 32'd0);

        // Reset in the middle of a slow refill.
        mem_delay = 3;
        sbq.push_back('{1'b0, 32'h80, 32'd0});
        sbq.push_back('{1'b0, 32'h84, 32'd0});
        a0 = acks;
        seen = 1'b0;
        cpu_addr = 32'h80;
        cpu_we   = 1'b0;
        cpu_req  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (acks - a0 >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_two_acks", {31'd0, seen}, 32'd1);
        @(negedge clk);
        #1;
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_hit_80", {31'd0, hit}, 32'd0);
        cpu_addr = 32'h40;
        #1;
        chk("abort_hit_40", {31'd0, hit}, 32'd0);
        chk("abort_sbq_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
